// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit: instruction
// mnemonics, LSU state encoding, access size, byte-enable and lane helpers.
package rv32i_lsu_pkg;

  localparam int unsigned RV32I_INSTRUCTION_WIDTH = 32;
  localparam int unsigned MEM_BE_WIDTH            = 4;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef logic [1:0] lsu_state_t;
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_RESP = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_t;

  localparam logic [MEM_BE_WIDTH-1:0] MEM_BE_BYTE = 4'b0001;
  localparam logic [MEM_BE_WIDTH-1:0] MEM_BE_HALF = 4'b0011;
  localparam logic [MEM_BE_WIDTH-1:0] MEM_BE_WORD = 4'b1111;

  function automatic logic is_load(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return (m inside {LB, LH, LW, LBU, LHU});
  endfunction

  function automatic logic is_store(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return (m inside {SB, SH, SW});
  endfunction

  function automatic lsu_size_t access_size(input RV32I_INSTRUCTION_MNEMONIC_t m);
    case (m)
      LB, LBU, SB: return SIZE_BYTE;
      LH, LHU, SH: return SIZE_HALF;
      default:     return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input lsu_size_t sz, input logic [1:0] lo);
    case (sz)
      SIZE_HALF: return ~lo[0];
      SIZE_WORD: return (lo == 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [MEM_BE_WIDTH-1:0] byte_enable(input lsu_size_t sz,
                                                          input logic [1:0] lo);
    case (sz)
      SIZE_BYTE: return MEM_BE_WIDTH'(MEM_BE_BYTE << lo);
      SIZE_HALF: return MEM_BE_WIDTH'(MEM_BE_HALF << {lo[1], 1'b0});
      default:   return MEM_BE_WORD;
    endcase
  endfunction

  // Replicate the store operand across every lane it may land in.
  function automatic logic [RV32I_INSTRUCTION_WIDTH-1:0] store_lanes(
      input lsu_size_t sz, input logic [RV32I_INSTRUCTION_WIDTH-1:0] d);
    case (sz)
      SIZE_BYTE: return {4{d[7:0]}};
      SIZE_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Data-memory bus (req/gnt/rvalid). master = LSU side, slave = memory side.
// Signals: mem_req, mem_we, mem_addr, mem_be, mem_wdata (master out);
//          mem_gnt, mem_rvalid, mem_rdata (slave out).
interface rv32i_lsu_if;
  import rv32i_lsu_pkg::*;

  logic                               mem_req;
  logic                               mem_we;
  logic [RV32I_INSTRUCTION_WIDTH-1:0] mem_addr;
  logic [MEM_BE_WIDTH-1:0]            mem_be;
  logic [RV32I_INSTRUCTION_WIDTH-1:0] mem_wdata;
  logic                               mem_gnt;
  logic                               mem_rvalid;
  logic [RV32I_INSTRUCTION_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_lsu_load_align.sv
// Load lane select and sign/zero extension (purely combinational).
// Ports: mnemonic (load op), lane (addr[1:0]), rdata (bus word) -> load_data_c.
module rv32i_lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  RV32I_INSTRUCTION_MNEMONIC_t        mnemonic,
  input  logic [1:0]                         lane,
  input  logic [RV32I_INSTRUCTION_WIDTH-1:0] rdata,
  output logic [RV32I_INSTRUCTION_WIDTH-1:0] load_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c      = rdata[{lane, 3'b000} +: 8];
    half_c      = rdata[{lane[1], 4'b0000} +: 16];
    load_data_c = rdata;
    case (mnemonic)
      LB:      load_data_c = {{24{byte_c[7]}}, byte_c};
      LBU:     load_data_c = {24'h0, byte_c};
      LH:      load_data_c = {{16{half_c[15]}}, half_c};
      LHU:     load_data_c = {16'h0, half_c};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time on a req/gnt/rvalid bus.
// Ports: clk, rst_n; core side start/mnemonic/addr/store_data in,
//        stall (combinational), done, load_data, misaligned out;
//        mem (rv32i_lsu_if.master) data-memory bus.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  RV32I_INSTRUCTION_MNEMONIC_t        mnemonic,
  input  logic [RV32I_INSTRUCTION_WIDTH-1:0] addr,
  input  logic [RV32I_INSTRUCTION_WIDTH-1:0] store_data,
  output logic                               stall,
  output logic                               done,
  output logic [RV32I_INSTRUCTION_WIDTH-1:0] load_data,
  output logic                               misaligned,
  rv32i_lsu_if.master                        mem
);

  localparam int unsigned W = RV32I_INSTRUCTION_WIDTH;

  lsu_state_t                  state_q, state_d;
  RV32I_INSTRUCTION_MNEMONIC_t mnem_q, mnem_d;
  logic [1:0]                  lane_q, lane_d;
  logic                        req_q, req_d;
  logic                        we_q, we_d;
  logic [W-1:0]                maddr_q, maddr_d;
  logic [MEM_BE_WIDTH-1:0]     be_q, be_d;
  logic [W-1:0]                wdata_q, wdata_d;
  logic                        done_q, done_d;
  logic                        mis_q, mis_d;
  logic [W-1:0]                ld_q, ld_d;

  lsu_size_t                   size_c;
  logic                        mem_op_c;
  logic                        accept_c;
  logic                        reject_c;
  logic [W-1:0]                align_data_c;

  // Request decode in IDLE: accept aligned memory ops, reject misaligned ones.
  always_comb begin
    size_c   = access_size(mnemonic);
    mem_op_c = is_load(mnemonic) | is_store(mnemonic);
    accept_c = 1'b0;
    reject_c = 1'b0;
    if ((state_q == LSU_IDLE) && start && mem_op_c) begin
      if (is_aligned(size_c, addr[1:0])) accept_c = 1'b1;
      else                               reject_c = 1'b1;
    end
  end

  rv32i_lsu_load_align u_load_align (
    .mnemonic    (mnem_q),
    .lane        (lane_q),
    .rdata       (mem.mem_rdata),
    .load_data_c (align_data_c)
  );

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    mnem_d  = mnem_q;
    lane_d  = lane_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept_c) begin
          state_d = LSU_REQ;
          mnem_d  = mnemonic;
          lane_d  = addr[1:0];
          we_d    = is_store(mnemonic);
          maddr_d = {addr[W-1:2], 2'b00};
          be_d    = byte_enable(size_c, addr[1:0]);
          wdata_d = store_lanes(size_c, store_data);
        end
      end
      LSU_REQ: begin
        if (mem.mem_gnt) state_d = we_q ? LSU_DONE : LSU_RESP;
      end
      LSU_RESP: begin
        if (mem.mem_rvalid) begin
          ld_d    = align_data_c;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    req_d  = (state_d == LSU_REQ);
    done_d = (state_d == LSU_DONE);
    mis_d  = reject_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      mnem_q  <= LW;
      lane_q  <= 2'b00;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      mnem_q  <= mnem_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      ld_q    <= ld_d;
    end
  end

  // Stall covers the accepting cycle too, so the core holds before mem_req rises.
  assign stall = (state_q == LSU_REQ) || (state_q == LSU_RESP) || accept_c;

  assign done          = done_q;
  assign misaligned    = mis_q;
  assign load_data     = ld_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule
